// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution controller and its in-flight queue.
package branch_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRedirect = 2'd1,
    StHold     = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        pred_taken;
  } br_entry_t;

  // opcode[6:2] of a RISC-V conditional branch
  localparam logic [4:0] BranchOpcode = 5'b11000;

  localparam int unsigned HoldCntW = 4;

  // Correct next PC once the real direction of a queued branch is known.
  function automatic logic [31:0] redirect_target(br_entry_t e, logic taken);
    return taken ? e.target : (e.pc + 32'd4);
  endfunction

endpackage

// File: rtl/branch_fifo.sv
// In-order queue of in-flight conditional branches; flush empties it and drops any same-cycle push.
module branch_fifo
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  br_entry_t push_data_i,
  input  logic      pop_i,
  input  logic      flush_i,
  output logic      full_o,
  output logic      empty_o,
  output br_entry_t head_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  br_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A full queue can still accept an entry when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks in-flight conditional branches, resolves them in order, trains the predictor and
// drives flush/redirect plus a fixed fetch-stall window after each misprediction.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 f_valid,
  input  logic                 f_is_branch,
  input  logic                 f_pred_taken,
  input  logic [31:0]          f_pc,
  input  logic [31:0]          f_target,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic                 ex_actual_taken,
  output logic                 stall_fetch,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 update_en,
  output logic                 actual_taken,
  output logic [31:0]          update_pc,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] mispred_count,
  output logic                 underflow_err
);

  state_e                state_q, state_d;
  logic [HoldCntW-1:0]   hold_cnt_q, hold_cnt_d;

  logic                  flush_q, flush_d;
  logic [31:0]           redirect_pc_q, redirect_pc_d;
  logic                  update_en_q, update_en_d;
  logic                  actual_taken_q, actual_taken_d;
  logic [31:0]           update_pc_q, update_pc_d;
  logic [CNT_WIDTH-1:0]  br_count_q, br_count_d;
  logic [CNT_WIDTH-1:0]  mispred_count_q, mispred_count_d;
  logic                  underflow_q, underflow_d;

  logic                  fifo_full, fifo_empty;
  br_entry_t             head, push_entry;
  logic                  in_idle, ex_br, resolve, mispredict, push;

  assign in_idle    = (state_q == StIdle);
  assign ex_br      = ex_valid & ex_is_branch;
  // Outside IDLE the queue is empty by construction, so any resolution is wrong-path.
  assign resolve    = ex_br & ~fifo_empty & in_idle;
  assign mispredict = resolve & (ex_actual_taken != head.pred_taken);
  assign push       = f_valid & f_is_branch & in_idle & ~mispredict & (~fifo_full | resolve);

  assign push_entry = '{pc: f_pc, target: f_target, pred_taken: f_pred_taken};

  branch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (resolve),
    .flush_i    (mispredict),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head)
  );

  assign stall_fetch = ~reset & ((fifo_full & ~resolve) | ~in_idle);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mispredict) state_d = StRedirect;
      end
      StRedirect: begin
        state_d    = StHold;
        hold_cnt_d = HoldCntW'(HOLD_CYCLES);
      end
      StHold: begin
        hold_cnt_d = hold_cnt_q - 1'b1;
        if (hold_cnt_q <= 4'd1) state_d = StIdle;
      end
      default: begin
        state_d    = StIdle;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    flush_d         = mispredict;
    update_en_d     = resolve;
    redirect_pc_d   = redirect_pc_q;
    actual_taken_d  = actual_taken_q;
    update_pc_d     = update_pc_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    underflow_d     = underflow_q | (ex_br & fifo_empty & in_idle);
    if (resolve) begin
      actual_taken_d = ex_actual_taken;
      update_pc_d    = head.pc;
      if (br_count_q != '1) br_count_d = br_count_q + 1'b1;
    end
    if (mispredict) begin
      redirect_pc_d = redirect_target(head, ex_actual_taken);
      if (mispred_count_q != '1) mispred_count_d = mispred_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      hold_cnt_q      <= '0;
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
      update_en_q     <= 1'b0;
      actual_taken_q  <= 1'b0;
      update_pc_q     <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
      underflow_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      flush_q         <= flush_d;
      redirect_pc_q   <= redirect_pc_d;
      update_en_q     <= update_en_d;
      actual_taken_q  <= actual_taken_d;
      update_pc_q     <= update_pc_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
      underflow_q     <= underflow_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = flush_q;
  assign redirect_pc    = redirect_pc_q;
  assign update_en      = update_en_q;
  assign actual_taken   = actual_taken_q;
  assign update_pc      = update_pc_q;
  assign br_count       = br_count_q;
  assign mispred_count  = mispred_count_q;
  assign underflow_err  = underflow_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench: directed vector table, corner-case sequences and a randomized run
// against a queue-based reference model.
module tb_branch_resolve_ctrl;

  localparam int unsigned Depth = 4;
  localparam int unsigned Hold  = 2;
  localparam int unsigned CntW  = 4;
  localparam int          CntMax = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic            f_valid, f_is_branch, f_pred_taken;
  logic [31:0]     f_pc, f_target;
  logic            ex_valid, ex_is_branch, ex_actual_taken;
  logic            stall_fetch, flush, redirect_valid, update_en, actual_taken;
  logic [31:0]     redirect_pc, update_pc;
  logic [CntW-1:0] br_count, mispred_count;
  logic            underflow_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(
    .DEPTH      (Depth),
    .HOLD_CYCLES(Hold),
    .CNT_WIDTH  (CntW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .f_valid        (f_valid),
    .f_is_branch    (f_is_branch),
    .f_pred_taken   (f_pred_taken),
    .f_pc           (f_pc),
    .f_target       (f_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_actual_taken(ex_actual_taken),
    .stall_fetch    (stall_fetch),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .update_en      (update_en),
    .actual_taken   (actual_taken),
    .update_pc      (update_pc),
    .br_count       (br_count),
    .mispred_count  (mispred_count),
    .underflow_err  (underflow_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic fb, input logic fp, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic ev, input logic eb, input logic et);
    f_valid = fv; f_is_branch = fb; f_pred_taken = fp; f_pc = pc; f_target = tgt;
    ex_valid = ev; ex_is_branch = eb; ex_actual_taken = et;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_br(input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    drive(1'b1, 1'b1, pred, pc, tgt, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
  } ent_t;

  ent_t        mq[$];
  int          m_recov, m_br, m_mp;
  logic        m_uf, e_upd_en, e_act, e_fl;
  logic [31:0] e_upd_pc, e_rpc;

  task automatic model_reset();
    mq.delete();
    m_recov = 0; m_br = 0; m_mp = 0; m_uf = 1'b0;
    e_upd_en = 1'b0; e_act = 1'b0; e_fl = 1'b0; e_upd_pc = '0; e_rpc = '0;
  endtask

  // Advance the model by one cycle using the currently driven inputs.
  task automatic model_step(output logic exp_stall);
    logic ex_br, res, push;
    ent_t h, n;
    ex_br = ex_valid && ex_is_branch;
    res   = ex_br && (mq.size() > 0) && (m_recov == 0);
    exp_stall = ((mq.size() == Depth) && !res) || (m_recov > 0);
    e_upd_en = res;
    e_fl     = 1'b0;
    if (res) begin
      h = mq.pop_front();
      e_upd_pc = h.pc;
      e_act    = ex_actual_taken;
      if (m_br < CntMax) m_br++;
      if (ex_actual_taken != h.pred) begin
        e_fl  = 1'b1;
        e_rpc = ex_actual_taken ? h.tgt : h.pc + 32'd4;
        if (m_mp < CntMax) m_mp++;
        mq.delete();
      end
    end
    if (ex_br && !res && m_recov == 0) m_uf = 1'b1;
    push = f_valid && f_is_branch && (m_recov == 0) && !e_fl && (mq.size() < Depth);
    if (push) begin
      n.pc = f_pc; n.tgt = f_target; n.pred = f_pred_taken;
      mq.push_back(n);
    end
    if (e_fl) m_recov = 1 + Hold;
    else if (m_recov > 0) m_recov--;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic fv, fb, fp;
    logic [31:0] pc, tgt;
    logic ev, eb, et;
    logic stall, upd_en;
    logic [31:0] upd_pc;
    logic act, fl;
    logic [31:0] rpc;
    logic [3:0] br, mp;
    logic uf;
  } vec_t;

  localparam logic [31:0] Z = 32'h0;
  localparam logic O = 1'b1;
  localparam logic N = 1'b0;

  vec_t tbl[9];

  initial begin
    logic        es;
    logic [31:0] exp_pcs[4];

    reset = 1'b1;
    idle_in();

    // Reset state, checked while reset is still high.
    tick();
    chk("reset_stall", stall_fetch, 0);
    chk("reset_flush", flush, 0);
    chk("reset_redir_valid", redirect_valid, 0);
    chk("reset_redir_pc", redirect_pc, 0);
    chk("reset_update_en", update_en, 0);
    chk("reset_update_pc", update_pc, 0);
    chk("reset_br_count", br_count, 0);
    chk("reset_mispred_count", mispred_count, 0);
    chk("reset_underflow", underflow_err, 0);
    reset = 1'b0;

    //          fv fb fp pc        tgt       ev eb et st ue upd_pc    ac fl rpc       br    mp    uf
    tbl[0] = '{O, O, O, 32'h100, 32'h140, N, N, N, N, N, Z,        N, N, Z,        4'd0, 4'd0, N};
    tbl[1] = '{N, N, N, Z,       Z,       O, O, O, N, O, 32'h100,  O, N, Z,        4'd1, 4'd0, N};
    tbl[2] = '{O, O, O, 32'h200, 32'h180, N, N, N, N, N, Z,        N, N, Z,        4'd1, 4'd0, N};
    tbl[3] = '{O, O, O, 32'h250, 32'h260, O, O, N, N, O, 32'h200,  N, O, 32'h204,  4'd2, 4'd1, N};
    tbl[4] = '{O, O, O, 32'h300, 32'h340, N, N, N, O, N, Z,        N, N, Z,        4'd2, 4'd1, N};
    tbl[5] = '{N, N, N, Z,       Z,       O, O, O, O, N, Z,        N, N, Z,        4'd2, 4'd1, N};
    tbl[6] = '{N, N, N, Z,       Z,       N, N, N, O, N, Z,        N, N, Z,        4'd2, 4'd1, N};
    tbl[7] = '{N, N, N, Z,       Z,       O, O, O, N, N, Z,        N, N, Z,        4'd2, 4'd1, O};
    tbl[8] = '{N, N, N, Z,       Z,       N, N, N, N, N, Z,        N, N, Z,        4'd2, 4'd1, O};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].fv, tbl[i].fb, tbl[i].fp, tbl[i].pc, tbl[i].tgt,
            tbl[i].ev, tbl[i].eb, tbl[i].et);
      #1;
      chk($sformatf("tbl%0d_stall", i), stall_fetch, tbl[i].stall);
      tick();
      chk($sformatf("tbl%0d_update_en", i), update_en, tbl[i].upd_en);
      if (tbl[i].upd_en) begin
        chk($sformatf("tbl%0d_update_pc", i), update_pc, tbl[i].upd_pc);
        chk($sformatf("tbl%0d_actual_taken", i), actual_taken, tbl[i].act);
      end
      chk($sformatf("tbl%0d_flush", i), flush, tbl[i].fl);
      chk($sformatf("tbl%0d_redir_valid", i), redirect_valid, tbl[i].fl);
      if (tbl[i].fl) chk($sformatf("tbl%0d_redir_pc", i), redirect_pc, tbl[i].rpc);
      chk($sformatf("tbl%0d_br_count", i), br_count, tbl[i].br);
      chk($sformatf("tbl%0d_mispred_count", i), mispred_count, tbl[i].mp);
      chk($sformatf("tbl%0d_underflow", i), underflow_err, tbl[i].uf);
    end

    // Full queue: fifth push rejected, push+pop while full accepted.
    do_reset();
    for (int i = 0; i < 4; i++) push_br(32'h1000 + 32'(16 * i), 32'h2000, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h9999_0000, 32'h2000, 1'b0, 1'b0, 1'b0);
    #1;
    chk("full_stall", stall_fetch, 1);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h5000, 32'h5100, 1'b1, 1'b1, 1'b1);
    #1;
    chk("full_pop_stall", stall_fetch, 0);
    tick();
    chk("full_pop_update_en", update_en, 1);
    chk("full_pop_update_pc", update_pc, 32'h1000);
    idle_in();
    #1;
    chk("full_again_stall", stall_fetch, 1);
    exp_pcs[0] = 32'h1010; exp_pcs[1] = 32'h1020; exp_pcs[2] = 32'h1030; exp_pcs[3] = 32'h5000;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, Z, Z, 1'b1, 1'b1, 1'b1);
      tick();
      chk($sformatf("drain%0d_update_pc", k), update_pc, exp_pcs[k]);
    end
    tick();
    chk("drain_empty_update_en", update_en, 0);
    chk("drain_empty_underflow", underflow_err, 1);

    // Mispredict with three queued: queue emptied, wrong-path resolutions ignored.
    do_reset();
    for (int i = 0; i < 3; i++) push_br(32'h3000 + 32'(4 * i), 32'h3800, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h7000, 32'h7100, 1'b1, 1'b1, 1'b0);
    tick();
    chk("mp3_flush", flush, 1);
    chk("mp3_redir_pc", redirect_pc, 32'h3004);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, Z, Z, 1'b1, 1'b1, 1'b1);
      #1;
      chk($sformatf("mp3_hold%0d_stall", k), stall_fetch, 1);
      tick();
      chk($sformatf("mp3_hold%0d_update_en", k), update_en, 0);
    end
    idle_in();
    tick();
    chk("mp3_underflow_clear", underflow_err, 0);
    chk("mp3_br_count", br_count, 1);
    drive(1'b0, 1'b0, 1'b0, Z, Z, 1'b1, 1'b1, 1'b1);
    tick();
    chk("mp3_emptied_update_en", update_en, 0);
    chk("mp3_emptied_underflow", underflow_err, 1);

    // Reset during HOLD aborts recovery.
    do_reset();
    push_br(32'h4000, 32'h4800, 1'b0);
    drive(1'b0, 1'b0, 1'b0, Z, Z, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rh_redir_pc", redirect_pc, 32'h4800);
    idle_in();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rh_stall", stall_fetch, 0);
    chk("rh_flush", flush, 0);
    chk("rh_br_count", br_count, 0);
    chk("rh_mispred_count", mispred_count, 0);
    chk("rh_redir_pc_zero", redirect_pc, 0);
    tick();
    chk("rh_after_flush", flush, 0);
    chk("rh_after_stall", stall_fetch, 0);

    // Counter saturation with 4-bit counters.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push_br(32'h100 * 32'(i + 1), 32'h8000, 1'b1);
      drive(1'b0, 1'b0, 1'b0, Z, Z, 1'b1, 1'b1, 1'b0);
      tick();
      idle_in();
      repeat (1 + Hold) tick();
    end
    chk("sat_mispred_count", mispred_count, 15);
    chk("sat_br_count", br_count, 15);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      f_valid      = ($urandom_range(0, 9) < 7);
      f_is_branch  = ($urandom_range(0, 9) < 8);
      f_pred_taken = 1'($urandom_range(0, 1));
      f_pc         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      f_target     = $urandom();
      ex_valid     = ($urandom_range(0, 9) < 5);
      ex_is_branch = ($urandom_range(0, 9) < 8);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) ex_actual_taken = mq[0].pred;
      else ex_actual_taken = 1'($urandom_range(0, 1));
      #1;
      model_step(es);
      chk("rand_stall", stall_fetch, es);
      tick();
      chk("rand_update_en", update_en, e_upd_en);
      if (e_upd_en) begin
        chk("rand_update_pc", update_pc, e_upd_pc);
        chk("rand_actual_taken", actual_taken, e_act);
      end
      chk("rand_flush", flush, e_fl);
      chk("rand_redir_valid", redirect_valid, e_fl);
      if (e_fl) chk("rand_redir_pc", redirect_pc, e_rpc);
      chk("rand_br_count", br_count, m_br);
      chk("rand_mispred_count", mispred_count, m_mp);
      chk("rand_underflow", underflow_err, m_uf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight conditional-branch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, cycles of fetch stall after a redirect (1..15).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 f_valid  input  1  fetch-stage instruction valid.
REQ-007 f_is_branch  input  1  fetch instruction is a conditional branch (opcode[6:2]=11000).
REQ-008 f_pred_taken  input  1  predictor direction sent to fetch.
REQ-009 f_pc  input  32  branch PC.
REQ-010 f_target  input  32  branch target (PC + B-immediate).
REQ-011 ex_valid  input  1  execute-stage resolution valid.
REQ-012 ex_is_branch  input  1  execute instruction is a conditional branch.
REQ-013 ex_actual_taken  input  1  resolved direction.
REQ-014 stall_fetch  output  1  fetch must hold its current instruction.
REQ-015 flush  output  1  one-cycle pulse: kill all younger instructions.
REQ-016 redirect_valid  output  1  one-cycle pulse, coincident with flush.
REQ-017 redirect_pc  output  32  corrected next PC, valid while redirect_valid.
REQ-018 update_en  output  1  predictor training strobe.
REQ-019 actual_taken  output  1  direction to train, valid with update_en.
REQ-020 update_pc  output  32  PC to train, valid with update_en.
REQ-021 br_count  output  CNT_WIDTH  resolved conditional branches, saturating.
REQ-022 mispred_count  output  CNT_WIDTH  mispredictions, saturating.
REQ-023 underflow_err  output  1  sticky: resolution arrived with queue empty.

Function
REQ-024 Push {pc, target, pred_taken} when f_valid & f_is_branch & !full & state==IDLE & !mispredict-this-cycle.
REQ-025 Resolve (pop head) when ex_valid & ex_is_branch & queue non-empty; resolution is in program order.
REQ-026 Simultaneous push and pop with no mispredict SHALL leave occupancy unchanged; push when full is permitted only if a pop occurs the same cycle.
REQ-027 stall_fetch combinational = (full & !pop) | (state != IDLE).
REQ-028 On resolve: update_en, actual_taken, update_pc registered, asserted exactly one cycle after the resolve cycle.
REQ-029 Mispredict = resolve & (ex_actual_taken != head.pred_taken).
REQ-030 On mispredict: next cycle flush=redirect_valid=1, redirect_pc = actual_taken ? head.target : head.pc + 4 (mod 2^32); queue emptied in the mispredict cycle; any same-cycle push discarded.
REQ-031 FSM states IDLE, REDIRECT, HOLD: IDLE->REDIRECT on mispredict; REDIRECT->HOLD after 1 cycle, loading hold counter with HOLD_CYCLES; HOLD decrements, HOLD->IDLE when counter reaches 1.
REQ-032 Resolutions arriving in REDIRECT/HOLD SHALL be ignored (wrong path, queue empty) and SHALL NOT set underflow_err.
REQ-033 Resolve in IDLE with empty queue SHALL set underflow_err and produce no update/redirect.
REQ-034 br_count increments on each valid resolve; mispred_count on each mispredict; both saturate at all-ones.
REQ-035 Queue pointers wrap modulo DEPTH; full/empty derived from a log2(DEPTH)+1-bit occupancy count.

Reset
REQ-036 In the reset cycle: state=IDLE, queue empty, hold counter 0, all outputs 0 (stall_fetch 0, redirect_pc 0, update_pc 0, counters 0, underflow_err 0).
REQ-037 Reset asserted mid-REDIRECT/HOLD SHALL abort recovery immediately; no flush pulse after reset.

Structure
REQ-038 Shared package branch_pkg SHALL hold the FSM state enum, the queue-entry struct {pc, target, pred_taken} and the branch opcode constant 5'b11000.
REQ-039 The in-flight queue SHALL be a sub-module branch_fifo (DEPTH, push/pop/flush, full/empty, head data); FSM, counters and update logic stay in the top.

Verification
REQ-040 Push pc=0x100, target=0x140, pred=1; resolve taken=1 -> next cycle update_en=1, update_pc=0x100, actual_taken=1, no flush, br_count=1.
REQ-041 Push pc=0x200, target=0x180, pred=1; resolve taken=0 -> next cycle flush=redirect_valid=1, redirect_pc=0x204; stall_fetch high 1+HOLD_CYCLES=3 cycles; mispred_count=1.
REQ-042 Push 4 branches without resolve -> stall_fetch=1, 5th push rejected; same-cycle push+pop when full accepted, occupancy stays 4.
REQ-043 Three entries queued, mispredict on head -> queue empty, later ex resolutions during HOLD ignored, underflow_err stays 0.
REQ-044 Resolve with empty queue in IDLE -> underflow_err=1 and remains 1 until reset.
REQ-045 Reset asserted during HOLD -> next cycle state IDLE, stall_fetch=0, all counters 0; CNT_WIDTH=4 bench: 20 mispredicts -> mispred_count=15.
